ibex_dummy_instr_gen: RTL

IBEX_DUMMY_INSTR_GEN -- requirements
Module: ibex_dummy_instr_gen

---
 rtl/ibex_pkg.sv | 39 +++
 rtl/prim_lfsr.sv | 41 ++++
 rtl/ibex_dummy_instr_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types and encodings for the dummy instruction generator.
// Holds the op/state enums, R-type field constants and LFSR tap selection.
package ibex_pkg;

  typedef enum logic [1:0] {
    DummyAdd = 2'b00,
    DummyMul = 2'b01,
    DummyDiv = 2'b10,
    DummyAnd = 2'b11
  } dummy_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCount  = 2'b01,
    StInsert = 2'b10
  } dummy_state_e;

  localparam logic [6:0] OpcodeOp     = 7'h33;
  localparam logic [6:0] Funct7Base   = 7'b0000000;
  localparam logic [6:0] Funct7Muldiv = 7'b0000001;
  localparam logic [2:0] Funct3Add    = 3'b000;
  localparam logic [2:0] Funct3Mul    = 3'b000;
  localparam logic [2:0] Funct3Div    = 3'b100;
  localparam logic [2:0] Funct3And    = 3'b111;

  localparam logic [63:0] LfsrDefaultSeed = 64'h5A5A_C3E1_9E37_79B9;

  // Galois (right-shift) feedback masks; unlisted widths still run but are not maximal length.
  function automatic logic [63:0] lfsr_taps(int unsigned width);
    case (width)
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return (64'd1 << (width - 1)) | 64'd3;
    endcase
  endfunction

endpackage

// File: rtl/prim_lfsr.sv
// Galois LFSR with seed load (priority) and step enable.
// Exposes the low StateOutDw bits of the current and next state.
module prim_lfsr #(
  parameter int unsigned      LfsrDw      = 32,
  parameter int unsigned      StateOutDw  = 17,
  parameter logic [LfsrDw-1:0] DefaultSeed = LfsrDw'(1),
  parameter logic [LfsrDw-1:0] Taps        = LfsrDw'(3)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  seed_en_i,
  input  logic [LfsrDw-1:0]     seed_i,
  input  logic                  lfsr_en_i,
  output logic [StateOutDw-1:0] state_o,
  output logic [StateOutDw-1:0] state_next_o
);

  logic [LfsrDw-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_en_i) begin
      // An all-zero state would lock up, so fall back to the default seed.
      lfsr_d = (seed_i == '0) ? DefaultSeed : seed_i;
    end else if (lfsr_en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ ({LfsrDw{lfsr_q[0]}} & Taps);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= DefaultSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o      = lfsr_q[StateOutDw-1:0];
  assign state_next_o = lfsr_d[StateOutDw-1:0];

endmodule

// File: rtl/ibex_dummy_instr_gen.sv
// Inserts randomised R-type dummy instructions (rd = x0) between real instructions.
// Define IBEX_DUMMY_INSTR_PERF_EN to build the saturating accepted-dummy counter.
module ibex_dummy_instr_gen
  import ibex_pkg::*;
#(
  parameter int unsigned TimeoutCntW = 5,
  parameter int unsigned BurstW      = 2,
  parameter int unsigned LfsrDw      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   dummy_instr_en_i,
  input  logic [TimeoutCntW-1:0] dummy_instr_mask_i,
  input  logic [3:0]             dummy_op_en_i,
  input  logic [BurstW-1:0]      dummy_burst_len_i,
  input  logic                   dummy_instr_seed_en_i,
  input  logic [LfsrDw-1:0]      dummy_instr_seed_i,
  input  logic                   fetch_valid_i,
  input  logic                   id_in_ready_i,
  output logic                   insert_dummy_instr_o,
  output logic [31:0]            dummy_instr_data_o,
  output logic [31:0]            dummy_instr_cnt_o
);

  localparam int unsigned StateOutDw = 12 + TimeoutCntW;
  localparam logic [63:0] Taps64     = lfsr_taps(LfsrDw);

  dummy_state_e            state_q, state_d;
  logic [TimeoutCntW-1:0]  cnt_q, cnt_d;
  logic [TimeoutCntW-1:0]  thr_q, thr_d;
  logic [BurstW-1:0]       burst_q, burst_d;
  logic [LfsrDw-1:0]       seed_q, seed_d;

  logic [StateOutDw-1:0]   lfsr_state, lfsr_state_next;
  logic                    real_issue, dummy_accept;
  dummy_op_e               op_raw, op_sel;
  logic [6:0]              funct7;
  logic [2:0]              funct3;

  assign seed_d = seed_q ^ dummy_instr_seed_i;

  prim_lfsr #(
    .LfsrDw      (LfsrDw),
    .StateOutDw  (StateOutDw),
    .DefaultSeed (LfsrDefaultSeed[LfsrDw-1:0]),
    .Taps        (Taps64[LfsrDw-1:0])
  ) u_lfsr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .seed_en_i    (dummy_instr_seed_en_i),
    .seed_i       (seed_d),
    .lfsr_en_i    (dummy_accept),
    .state_o      (lfsr_state),
    .state_next_o (lfsr_state_next)
  );

  logic unused_lfsr_next;
  assign unused_lfsr_next = ^lfsr_state_next[StateOutDw-1:TimeoutCntW];

  assign real_issue           = fetch_valid_i & id_in_ready_i;
  assign insert_dummy_instr_o = (state_q == StInsert) & dummy_instr_en_i;
  assign dummy_accept         = insert_dummy_instr_o & id_in_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    burst_d = burst_q;
    if (!dummy_instr_en_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      burst_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StCount;
          cnt_d   = '0;
          thr_d   = lfsr_state[TimeoutCntW-1:0] & dummy_instr_mask_i;
        end
        StCount: begin
          if (cnt_q == thr_q) begin
            state_d = StInsert;
            burst_d = dummy_burst_len_i;
          end else if (real_issue) begin
            cnt_d = cnt_q + TimeoutCntW'(1);
          end
        end
        StInsert: begin
          if (dummy_accept) begin
            if (burst_q == '0) begin
              state_d = StCount;
              cnt_d   = '0;
              // Threshold comes from the value the LFSR steps to on this acceptance.
              thr_d   = lfsr_state_next[TimeoutCntW-1:0] & dummy_instr_mask_i;
            end else begin
              burst_d = burst_q - BurstW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      thr_q   <= '0;
      burst_q <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      burst_q <= burst_d;
      if (dummy_instr_seed_en_i) begin
        seed_q <= seed_d;
      end
    end
  end

  assign op_raw = dummy_op_e'(lfsr_state[TimeoutCntW+10 +: 2]);

  always_comb begin
    op_sel = op_raw;
    if (!dummy_op_en_i[op_raw]) begin
      op_sel = DummyAdd;
    end
    funct7 = Funct7Base;
    funct3 = Funct3Add;
    case (op_sel)
      DummyMul: begin funct7 = Funct7Muldiv; funct3 = Funct3Mul; end
      DummyDiv: begin funct7 = Funct7Muldiv; funct3 = Funct3Div; end
      DummyAnd: begin funct7 = Funct7Base;   funct3 = Funct3And; end
      default:  begin funct7 = Funct7Base;   funct3 = Funct3Add; end
    endcase
  end

  assign dummy_instr_data_o = {funct7, lfsr_state[TimeoutCntW+5 +: 5], lfsr_state[TimeoutCntW +: 5],
                               funct3, 5'h00, OpcodeOp};

`ifdef IBEX_DUMMY_INSTR_PERF_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt_q <= '0;
    end else if (!dummy_instr_en_i) begin
      perf_cnt_q <= '0;
    end else if (dummy_accept && (perf_cnt_q != '1)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign dummy_instr_cnt_o = perf_cnt_q;
`else
  assign dummy_instr_cnt_o = '0;
`endif

endmodule
